// File: rtl/wb_port_sched.sv
// Write-back port scheduler: serialises one E/M write bundle
// onto a single register-file write port, M wins on collisions.
module wb_port_sched #(
  parameter int         DATA_W = 64,
  parameter logic [3:0] RNONE  = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [3:0]        dstE,
  input  logic [DATA_W-1:0] valE,
  input  logic [3:0]        dstM,
  input  logic [DATA_W-1:0] valM,
  output logic              rf_we,
  output logic [3:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              wb_done,
  output logic              busy,
  output logic [15:0]       retired_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    WR_E,
    WR_M,
    DONE
  } state_t;

  typedef struct packed {
    logic [3:0]        dste;
    logic [DATA_W-1:0] vale;
    logic [3:0]        dstm;
    logic [DATA_W-1:0] valm;
    logic              need_e;
    logic              need_m;
  } bundle_t;

  state_t  state;
  state_t  nxt;
  state_t  post;
  bundle_t cap;
  bundle_t in_b;
  logic    accept;

  assign wb_ready = (state == IDLE) || (state == DONE);
  assign accept   = wb_valid && wb_ready;

  // Decode the incoming bundle; a shared E/M target keeps only M.
  always_comb begin
    in_b        = '0;
    in_b.dste   = dstE;
    in_b.vale   = valE;
    in_b.dstm   = dstM;
    in_b.valm   = valM;
    in_b.need_e = (dstE != RNONE) && (dstE != dstM);
    in_b.need_m = (dstM != RNONE);
    if (in_b.need_e) begin
      post = WR_E;
    end else if (in_b.need_m) begin
      post = WR_M;
    end else begin
      post = DONE;
    end
  end

  // Next-state selection.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: nxt = accept ? post : IDLE;
      WR_E: nxt = cap.need_m ? WR_M : DONE;
      WR_M: nxt = DONE;
      DONE: nxt = accept ? post : IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Moore write-port and status decode.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = RNONE;
    rf_wdata = '0;
    wb_done  = 1'b0;
    unique case (1'b1)
      (state == WR_E): begin
        rf_we    = 1'b1;
        rf_waddr = cap.dste;
        rf_wdata = cap.vale;
      end
      (state == WR_M): begin
        rf_we    = 1'b1;
        rf_waddr = cap.dstm;
        rf_wdata = cap.valm;
      end
      (state == DONE): wb_done = 1'b1;
      default: ;
    endcase
  end

  assign busy = (state != IDLE) &&
                !((state == DONE) && !accept);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Bundle capture on handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap      <= '0;
      cap.dste <= RNONE;
      cap.dstm <= RNONE;
    end else if (accept) begin
      cap <= in_b;
    end
  end

  // Retired count is visible in the DONE cycle itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_cnt <= '0;
    end else if (nxt == DONE) begin
      retired_cnt <= retired_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_wb_port_sched.sv
// Directed bench for wb_port_sched: latency, collapse,
// back-to-back, mid-op reset and counter wrap.
module tb_wb_port_sched;

  localparam int DW = 64;
  localparam logic [3:0] RN = 4'hF;

  logic          clk;
  logic          rst;
  logic          wb_valid;
  logic          wb_ready;
  logic [3:0]    dstE;
  logic [DW-1:0] valE;
  logic [3:0]    dstM;
  logic [DW-1:0] valM;
  logic          rf_we;
  logic [3:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          wb_done;
  logic          busy;
  logic [15:0]   retired_cnt;

  int passed;
  int total;

  wb_port_sched #(.DATA_W(DW), .RNONE(RN)) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .dstE        (dstE),
    .valE        (valE),
    .dstM        (dstM),
    .valM        (valM),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .wb_done     (wb_done),
    .busy        (busy),
    .retired_cnt (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] de,
                       input logic [DW-1:0] ve,
                       input logic [3:0] dm,
                       input logic [DW-1:0] vm);
    wb_valid = v;
    dstE = de;
    valE = ve;
    dstM = dm;
    valM = vm;
  endtask

  task automatic test_reset();
    total++;
    if ({rf_we, rf_waddr, rf_wdata, wb_done, busy, retired_cnt, wb_ready}
        !== {1'b0, RN, 64'd0, 1'b0, 1'b0, 16'd0, 1'b1})
      $display("FAIL reset: we=%0b a=%h d=%h done=%0b busy=%0b cnt=%0d rdy=%0b want 0 f 0 0 0 0 1",
               rf_we, rf_waddr, rf_wdata, wb_done, busy, retired_cnt, wb_ready);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int bad;
    drive(1'b1, 4'd3, 64'h11, 4'd5, 64'h22);
    step();
    drive(1'b0, RN, 64'd0, RN, 64'd0);
    total++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'd3, 64'h11})
      $display("FAIL mid_wre: we=%0b a=%h d=%h want 1 3 11",
               rf_we, rf_waddr, rf_wdata);
    else passed++;
    rst = 1'b0;
    #1;
    total++;
    if ({rf_we, rf_waddr, wb_ready, busy, wb_done, retired_cnt}
        !== {1'b0, RN, 1'b1, 1'b0, 1'b0, 16'd0})
      $display("FAIL mid_async: we=%0b a=%h rdy=%0b busy=%0b done=%0b cnt=%0d want 0 f 1 0 0 0",
               rf_we, rf_waddr, wb_ready, busy, wb_done, retired_cnt);
    else passed++;
    step();
    #2 rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rf_we || wb_done) bad++;
    end
    total++;
    if (bad !== 0 || retired_cnt !== 16'd0)
      $display("FAIL mid_after: bad_cycles=%0d cnt=%0d want 0 0",
               bad, retired_cnt);
    else passed++;
  endtask

  task automatic test_two_write();
    drive(1'b1, 4'd3, 64'h11, 4'd5, 64'h22);
    total++;
    if (wb_ready !== 1'b1)
      $display("FAIL tw_ready0: got %0b want 1", wb_ready);
    else passed++;
    step();
    drive(1'b0, RN, 64'd0, RN, 64'd0);
    total++;
    if ({rf_we, rf_waddr, rf_wdata, wb_ready, busy}
        !== {1'b1, 4'd3, 64'h11, 1'b0, 1'b1})
      $display("FAIL tw_c1: we=%0b a=%h d=%h rdy=%0b busy=%0b want 1 3 11 0 1",
               rf_we, rf_waddr, rf_wdata, wb_ready, busy);
    else passed++;
    step();
    total++;
    if ({rf_we, rf_waddr, rf_wdata, wb_ready, wb_done}
        !== {1'b1, 4'd5, 64'h22, 1'b0, 1'b0})
      $display("FAIL tw_c2: we=%0b a=%h d=%h rdy=%0b done=%0b want 1 5 22 0 0",
               rf_we, rf_waddr, rf_wdata, wb_ready, wb_done);
    else passed++;
    step();
    total++;
    if ({wb_done, rf_we, rf_waddr, rf_wdata, busy, wb_ready, retired_cnt}
        !== {1'b1, 1'b0, RN, 64'd0, 1'b0, 1'b1, 16'd1})
      $display("FAIL tw_c3: done=%0b we=%0b a=%h d=%h busy=%0b rdy=%0b cnt=%0d want 1 0 f 0 0 1 1",
               wb_done, rf_we, rf_waddr, rf_wdata, busy, wb_ready, retired_cnt);
    else passed++;
    step();
    total++;
    if ({wb_done, busy, retired_cnt} !== {1'b0, 1'b0, 16'd1})
      $display("FAIL tw_c4: done=%0b busy=%0b cnt=%0d want 0 0 1",
               wb_done, busy, retired_cnt);
    else passed++;
  endtask

  task automatic test_collapse();
    drive(1'b1, 4'd4, 64'h100, 4'd4, 64'h200);
    step();
    drive(1'b0, RN, 64'd0, RN, 64'd0);
    total++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'd4, 64'h200})
      $display("FAIL col_c1: we=%0b a=%h d=%h want 1 4 200",
               rf_we, rf_waddr, rf_wdata);
    else passed++;
    step();
    total++;
    if ({wb_done, rf_we, retired_cnt} !== {1'b1, 1'b0, 16'd2})
      $display("FAIL col_c2: done=%0b we=%0b cnt=%0d want 1 0 2",
               wb_done, rf_we, retired_cnt);
    else passed++;
    step();
    total++;
    if ({wb_done, rf_we} !== {1'b0, 1'b0})
      $display("FAIL col_c3: done=%0b we=%0b want 0 0",
               wb_done, rf_we);
    else passed++;
  endtask

  task automatic test_nop();
    drive(1'b1, RN, 64'h55, RN, 64'h66);
    step();
    drive(1'b0, RN, 64'd0, RN, 64'd0);
    total++;
    if ({wb_done, rf_we, retired_cnt} !== {1'b1, 1'b0, 16'd3})
      $display("FAIL nop_c1: done=%0b we=%0b cnt=%0d want 1 0 3",
               wb_done, rf_we, retired_cnt);
    else passed++;
    step();
    total++;
    if ({wb_done, rf_we, busy} !== {1'b0, 1'b0, 1'b0})
      $display("FAIL nop_c2: done=%0b we=%0b busy=%0b want 0 0 0",
               wb_done, rf_we, busy);
    else passed++;
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 4'd2, 64'hAA, RN, 64'hBB);
    step();
    total++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'd2, 64'hAA})
      $display("FAIL b2b_c1: we=%0b a=%h d=%h want 1 2 aa",
               rf_we, rf_waddr, rf_wdata);
    else passed++;
    drive(1'b1, RN, 64'hCC, 4'd7, 64'h77);
    step();
    total++;
    if ({wb_done, rf_we, wb_ready, busy, retired_cnt}
        !== {1'b1, 1'b0, 1'b1, 1'b1, 16'd4})
      $display("FAIL b2b_c2: done=%0b we=%0b rdy=%0b busy=%0b cnt=%0d want 1 0 1 1 4",
               wb_done, rf_we, wb_ready, busy, retired_cnt);
    else passed++;
    step();
    drive(1'b0, RN, 64'd0, RN, 64'd0);
    total++;
    if ({rf_we, rf_waddr, rf_wdata, wb_done}
        !== {1'b1, 4'd7, 64'h77, 1'b0})
      $display("FAIL b2b_c3: we=%0b a=%h d=%h done=%0b want 1 7 77 0",
               rf_we, rf_waddr, rf_wdata, wb_done);
    else passed++;
    step();
    total++;
    if ({wb_done, busy, retired_cnt} !== {1'b1, 1'b0, 16'd5})
      $display("FAIL b2b_c4: done=%0b busy=%0b cnt=%0d want 1 0 5",
               wb_done, busy, retired_cnt);
    else passed++;
    step();
  endtask

  task automatic test_wrap();
    rst = 1'b0;
    #2 rst = 1'b1;
    step();
    drive(1'b1, RN, 64'd0, RN, 64'd0);
    repeat (65535) step();
    total++;
    if ({retired_cnt, wb_done} !== {16'hFFFF, 1'b1})
      $display("FAIL wrap_ffff: cnt=%h done=%0b want ffff 1",
               retired_cnt, wb_done);
    else passed++;
    step();
    drive(1'b0, RN, 64'd0, RN, 64'd0);
    total++;
    if (retired_cnt !== 16'h0000)
      $display("FAIL wrap_zero: cnt=%h want 0000", retired_cnt);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total = 0;
    rst = 1'b0;
    drive(1'b0, RN, 64'd0, RN, 64'd0);
    #1;
    test_reset();
    #20 rst = 1'b1;
    step();
    test_reset_mid();
    test_two_write();
    test_collapse();
    test_nop();
    test_back_to_back();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wb_port_sched.md
# wb_port_sched

Write-back port scheduler for the SEQ processor. Each cycle the write-back stage can produce two register writes: one for `dstE` with `valE`, and one for `dstM` with `valM`. The register file has a single write port, so this block accepts one bundle through a valid/ready handshake and drives the port with one write per cycle. When both destinations name the same register, it applies the rule that the M write wins. It sits between the write-back destination logic and the register file write port, and it back-pressures the stage sequencer through `wb_ready`.

## Interface
- `DATA_W`, default 64: register data width.
- `RNONE`, default 4'hF: register ID meaning "no destination".
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `wb_valid`  in  1: a write-back bundle is present on `dstE`/`valE`/`dstM`/`valM`.
- `wb_ready`  out  1: the block accepts a bundle this cycle.
- `dstE`  in  4: E-destination register ID, or `RNONE`.
- `valE`  in  DATA_W: E write data.
- `dstM`  in  4: M-destination register ID, or `RNONE`.
- `valM`  in  DATA_W: M write data.
- `rf_we`  out  1: register-file write enable.
- `rf_waddr`  out  4: register-file write address.
- `rf_wdata`  out  DATA_W: register-file write data.
- `wb_done`  out  1: one-cycle pulse when the accepted bundle is fully retired.
- `busy`  out  1: a bundle is held and not yet retired.
- `retired_cnt`  out  16: count of retired bundles; wraps modulo 2^16.

## Operation
- States: IDLE, WR_E, WR_M, DONE. Outputs are Moore, decoded from state and the captured bundle registers.
- Acceptance: a handshake completes when `wb_valid && wb_ready`.
  - `wb_ready` is 1 in IDLE and DONE, and 0 in WR_E and WR_M.
- Capture at acceptance: register `dstE`, `valE`, `dstM`, `valM`, and compute these flags:
  - `needE` = (`dstE` != RNONE) && !(`dstE` == `dstM`).
  - `needM` = (`dstM` != RNONE).
  - Collapse rule: when `dstE` == `dstM` != RNONE, only the M write happens (popq %rsp semantics).
- Next state after acceptance, from IDLE or DONE:
  - WR_E if `needE`;
  - else WR_M if `needM`;
  - else DONE.
- WR_E: `rf_we`=1, `rf_waddr`=captured `dstE`, `rf_wdata`=captured `valE`. Next state is WR_M if `needM`, else DONE.
- WR_M: `rf_we`=1, `rf_waddr`=captured `dstM`, `rf_wdata`=captured `valM`. Next state is DONE.
- DONE: `wb_done`=1 and `retired_cnt` increments on this edge. Next state is the post-acceptance state if a new bundle is accepted this cycle, else IDLE.
- IDLE: `rf_we`=0, `wb_done`=0. The block stays in IDLE until a bundle is accepted.
- In any state without a write: `rf_we`=0, `rf_waddr`=RNONE, `rf_wdata`=0.
- `busy` = (state != IDLE) && !(state == DONE && no acceptance this cycle).
  - Equivalently, `busy` is 1 in WR_E and WR_M, and 1 in DONE only when a new bundle is being accepted.
- Upstream holding rule: while `wb_ready`=0, upstream must hold `wb_valid` and the data stable. The block ignores the inputs in those cycles.

## Timing
- Reset (`rst`=0, asynchronous):
  - state=IDLE, captured IDs=RNONE, captured data=0.
  - `rf_we`=0, `rf_waddr`=RNONE, `rf_wdata`=0.
  - `wb_done`=0, `busy`=0, `retired_cnt`=0.
  - `wb_ready`=1, decoded from IDLE.
- Latency, counted from the acceptance edge at cycle 0:
  - Two writes: E write in cycle 1, M write in cycle 2, `wb_done` in cycle 3.
  - One write: the write in cycle 1, `wb_done` in cycle 2.
  - No write: `wb_done` in cycle 1.
- Throughput: a new bundle can be accepted in the DONE cycle. Back-to-back bundles therefore cost (writes + 1) cycles each.
- Reset mid-operation: the block returns to IDLE immediately and the pending bundle is lost. A write already performed stays; the next write is never issued. `wb_done` is not pulsed and the count does not increment.
- Counter wrap: `retired_cnt` goes 16'hFFFF → 16'h0000 with no flag.

## Test plan
- Reset, then bundle `dstE`=3, `valE`=0x11, `dstM`=5, `valM`=0x22 → cycle 1 writes (3, 0x11); cycle 2 writes (5, 0x22); cycle 3 `wb_done`=1, `retired_cnt`=1; `wb_ready`=0 in cycles 1–2.
- Bundle with `dstE`=`dstM`=4 (RSP), `valE`=0x100, `valM`=0x200 → a single write (4, 0x200) in cycle 1, `wb_done` in cycle 2, no write of 0x100.
- Bundle with `dstE`=`dstM`=RNONE (nop/halt) → `rf_we` never asserts, `wb_done` in cycle 1, `retired_cnt` increments.
- Back-to-back: hold `wb_valid` with an E-only bundle (`dstE`=2), then an M-only bundle (`dstM`=7) accepted in DONE → writes in cycle 1 and cycle 3, `wb_done` in cycles 2 and 4, no idle gap.
- Assert `rst`=0 during WR_E of a two-write bundle → next edge is IDLE with `rf_we`=0, the M write is never issued, `retired_cnt` unchanged, `wb_ready`=1.
- Preload-free wrap: retire 65536 empty bundles → `retired_cnt` returns to 0.
